// File: rtl/word_read_arbiter.sv
// rtl/word_read_arbiter.sv - two-requester burst read arbiter for a shared word FIFO
//
// Gives the FIFO read port to one of two requesters at a time, using
// round-robin when both ask. The granted burst is read one word at a time,
// and each word is handed over with a valid/ready handshake.
//
// Ports:
//   clock, rstn            clock; asynchronous active-low reset
//   fifo_empty, fifo_data  FIFO status and read data (data valid the cycle after fifo_rd)
//   fifo_rd                one-cycle FIFO read strobe per word
//   req0/1, len0/1         burst requests and word counts (count sampled at grant)
//   gnt0/1                 requester owns the read port
//   data_out, valid0/1     delivered word and per-requester valid
//   ready0/1               requester accepts data_out
//   done0/1                one-cycle pulse when a burst ends
//   busy                   arbiter is not idle

module word_read_arbiter #(
   parameter int WORD_SIZE = 32,
   parameter int BURST_W   = 4
) (
   input  logic                 clock,
   input  logic                 rstn,
   input  logic                 fifo_empty,
   input  logic [WORD_SIZE-1:0] fifo_data,
   output logic                 fifo_rd,
   input  logic                 req0,
   input  logic                 req1,
   input  logic [BURST_W-1:0]   len0,
   input  logic [BURST_W-1:0]   len1,
   output logic                 gnt0,
   output logic                 gnt1,
   output logic [WORD_SIZE-1:0] data_out,
   output logic                 valid0,
   output logic                 valid1,
   input  logic                 ready0,
   input  logic                 ready1,
   output logic                 done0,
   output logic                 done1,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, READ, CAPT, SEND} state_t;

   state_t             state;
   logic               owner;     // requester holding the grant
   logic               last;      // requester served last; reset to 1 so requester 0 wins the first tie
   logic [BURST_W-1:0] count;     // words still to deliver
   logic               stop;      // owner dropped req during CAPT/SEND; burst ends after this word

   logic elig0;
   logic elig1;
   logic pick;
   logic req_cur;
   logic ready_cur;
   logic last_word;

   assign elig0 = req0 && (len0 != '0);
   assign elig1 = req1 && (len1 != '0);

   // On a tie the requester not served last wins. Otherwise the single eligible one wins.
   assign pick = (elig0 && elig1) ? ~last : elig1;

   assign req_cur   = owner ? req1 : req0;
   assign ready_cur = owner ? ready1 : ready0;

   // The read strobe is decoded from the current state so it can never coincide
   // with an empty FIFO. An abort in READ also suppresses it in the same cycle.
   assign fifo_rd = (state == READ) && !fifo_empty && req_cur;
   assign busy    = (state != IDLE);

   assign last_word = (count == BURST_W'(1)) || stop || !req_cur;

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         owner    <= 1'b0;
         last     <= 1'b1;
         count    <= '0;
         stop     <= 1'b0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         valid0   <= 1'b0;
         valid1   <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         data_out <= '0;
      end else begin
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            IDLE: begin
               if (elig0 || elig1) begin
                  owner <= pick;
                  count <= pick ? len1 : len0;
                  gnt0  <= ~pick;
                  gnt1  <= pick;
                  stop  <= 1'b0;
                  state <= READ;
               end
            end
            READ: begin
               if (!req_cur) begin
                  // Abort before reading: the rest of the burst is discarded.
                  done0 <= ~owner;
                  done1 <= owner;
                  gnt0  <= 1'b0;
                  gnt1  <= 1'b0;
                  last  <= owner;
                  count <= '0;
                  state <= IDLE;
               end else if (!fifo_empty) begin
                  state <= CAPT;
               end
            end
            CAPT: begin
               data_out <= fifo_data;
               valid0   <= ~owner;
               valid1   <= owner;
               if (!req_cur) stop <= 1'b1;
               state    <= SEND;
            end
            SEND: begin
               if (ready_cur) begin
                  valid0 <= 1'b0;
                  valid1 <= 1'b0;
                  if (last_word) begin
                     done0 <= ~owner;
                     done1 <= owner;
                     gnt0  <= 1'b0;
                     gnt1  <= 1'b0;
                     last  <= owner;
                     count <= '0;
                     state <= IDLE;
                  end else begin
                     count <= count - BURST_W'(1);
                     state <= READ;
                  end
               end else if (!req_cur) begin
                  stop <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/word_read_arbiter.md
WORD_READ_ARBITER -- requirements
Module: word_read_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 32: width of FIFO words and delivered data.
REQ-002 Parameter BURST_W, default 4: width of burst-length inputs and internal word counter.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 fifo_empty  input  1  empty flag from 32-bit word buffer.
REQ-006 fifo_data  input  WORD_SIZE  buffer read data, valid the cycle after fifo_rd.
REQ-007 fifo_rd  output  1  buffer read request, one-cycle pulse per word.
REQ-008 req0, req1  input  1  requester 0/1 asks for a burst.
REQ-009 len0, len1  input  BURST_W  requested word count; sampled at grant.
REQ-010 gnt0, gnt1  output  1  requester owns the FIFO read port.
REQ-011 data_out  output  WORD_SIZE  word delivered to granted requester.
REQ-012 valid0, valid1  output  1  data_out valid for requester 0/1.
REQ-013 ready0, ready1  input  1  requester 0/1 accepts data_out.
REQ-014 done0, done1  output  1  one-cycle pulse at end of requester's burst.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, READ, CAPT, SEND.
REQ-017 IDLE: eligible requester = reqN high and lenN != 0; none eligible -> stay IDLE.
REQ-018 IDLE, both eligible: round-robin; requester not served last wins; after reset requester 0 has priority.
REQ-019 IDLE, grant: latch lenN into count, assert gntN, go READ next cycle.
REQ-020 gntN SHALL stay high from grant until the cycle doneN pulses; gnt0 and gnt1 never both high.
REQ-021 READ: fifo_empty high -> stall in READ, fifo_rd low; fifo_empty low -> fifo_rd high exactly one cycle, go CAPT.
REQ-022 fifo_rd SHALL never assert while fifo_empty is high or outside READ.
REQ-023 CAPT: register fifo_data into data_out, assert validN of granted requester, go SEND.
REQ-024 SEND: data_out and validN held stable until readyN high; word transferred on the cycle validN and readyN are both high.
REQ-025 On transfer: count decrements by 1; count reaches 0 -> validN low, doneN pulse, gntN low, round-robin pointer records N, go IDLE; else -> READ.
REQ-026 Minimum throughput: one word per 3 cycles (READ, CAPT, SEND with readyN high).
REQ-027 Abort: reqN low while in READ -> no fifo_rd, doneN pulse, return to IDLE; remaining count discarded.
REQ-028 reqN low while in CAPT or SEND -> current word SHALL complete its handshake, then burst ends as in REQ-025 regardless of count.
REQ-029 readyN asserted without validN SHALL have no effect; ready of non-granted requester ignored.
REQ-030 len changes after grant SHALL not affect the running burst.
REQ-031 Counter arithmetic is BURST_W-bit unsigned; maximum burst 2^BURST_W-1 words, no wrap.

Reset
REQ-032 rstn low SHALL force, asynchronously: state IDLE, count 0, fifo_rd 0, gnt0/gnt1 0, valid0/valid1 0, done0/done1 0, busy 0, data_out 0, round-robin pointer favouring requester 0.
REQ-033 Reset mid-burst SHALL drop the burst with no doneN pulse; a word already read from the FIFO is lost.
REQ-034 First grant possible on the first rising edge after rstn deasserts.

Verification
REQ-035 Single burst: FIFO holds A1,A2,A3; req0=1, len0=3, ready0=1 -> three fifo_rd pulses, data_out A1,A2,A3 in order with valid0, done0 on the third transfer, busy low next cycle.
REQ-036 Contention: req0=req1=1, len0=len1=2, FIFO holds 4 words -> requester 0 gets words 1-2, then requester 1 gets words 3-4; repeat with both still requesting -> requester 1 wins next arbitration after requester 0.
REQ-037 Empty stall: len1=2, FIFO holds 1 word -> one word delivered, arbiter stalls in READ with fifo_rd low; push second word -> delivered, done1 pulses.
REQ-038 Backpressure: ready0 low 5 cycles while valid0 high -> data_out and valid0 stable, no extra fifo_rd, count unchanged.
REQ-039 Abort and reset: req0 dropped in READ with count 4 -> done0 pulse, no fifo_rd, IDLE; separate run: rstn low during SEND -> all outputs 0 immediately, no done pulse.
REQ-040 len0=0 with req0=1 -> no grant, busy stays low, fifo_rd never asserted.
